stat_report_sequencer: RTL and testbench
========================================

Name: stat_report_sequencer

Overview:
- Periodically, or on request, serialises a snapshot of the six pet stats plus the status byte into a fixed 6-byte frame.
- Feeds the frame to the UART transmitter over a valid/ready byte handshake.
- Sits between the stats/states modules and the uart module as the transmit-side controller.
- Arbitrates between periodic report ticks and manual report requests.

Parameters:
- TICKS_PER_REPORT, 1, number of `second` pulses between automatic reports (legal range 1..255).
- HEADER, 8'hA5, value of frame byte 0.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- second  input  1  one-cycle pulse, once per second.
- req  input  1  one-cycle manual report request.
- hunger  input  4  stat.
- happiness  input  4  stat.
- health  input  4  stat.
- hygiene  input  4  stat.
- energy  input  4  stat.
- social  input  4  stat.
- status  input  8  state byte from the states module.
- tx_ready  input  1  UART transmitter can accept a byte this cycle.
- tx_data  output  8  byte offered to the UART.
- tx_valid  output  1  tx_data is valid.
- busy  output  1  a frame is being sent.
- frame_count  output  8  number of completed frames, wraps.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high.
- Reset values: tx_valid=0, tx_data=0, busy=0, frame_count=0, tick counter=0, pending=0, state=IDLE.
- Reset mid-frame: on the first edge with reset high, all of the above are forced. The partial frame is abandoned and is not resumed.
- Frame layout: B0=HEADER, B1={hunger,happiness}, B2={health,hygiene}, B3={energy,social}, B4=status, B5=XOR of B0..B4.
- Trigger sources:
  - Tick counter increments on each `second` pulse. When it would reach TICKS_PER_REPORT it clears to 0 and raises an auto trigger.
  - Trigger = auto trigger OR req. Simultaneous req and auto trigger produce one frame.
- FSM IDLE:
  - On trigger, snapshot all stats/status into internal registers in the same cycle.
  - Go to SEND with index=0.
  - tx_valid=1 and busy=1 from the next cycle; latency trigger to first tx_valid is 1 cycle.
- FSM SEND:
  - tx_data = snapshot byte[index]; tx_valid held high with stable data until tx_ready=1.
  - A transfer occurs on a cycle with tx_valid & tx_ready. The next byte is presented the following cycle, so back-to-back transfers at one byte/cycle are allowed.
  - Checksum accumulates over the transferred bytes and is presented as B5.
  - On B5 transfer: frame_count+1 (255 wraps to 0).
    - If pending=1: clear pending, re-snapshot, start a new frame with index=0. tx_valid stays high with no bubble.
    - Otherwise go to IDLE; tx_valid=0 and busy=0 next cycle.
- Trigger during SEND: sets pending (one-deep). Further triggers while pending=1 are dropped.
- Trigger on the same cycle as the final B5 transfer: treated as pending and starts the next frame immediately.
- Stat changes during a frame do not affect it; only snapshot values are sent.
- tx_ready while tx_valid=0 is ignored.
- Tick counter runs independently of FSM state, including while busy.

Decomposition:
- Shared package (`report_pkg`):
  - Constant FRAME_LEN=6.
  - Default HEADER 8'hA5.
  - Byte-index localparams IDX_HDR..IDX_CSUM.
  - State encoding IDLE/SEND.
- Sub-module `report_tick_div`: the `second`-pulse divider.
  - Parameter TICKS_PER_REPORT.
  - Inputs clk, reset, second. Output one-cycle auto_trig.

Test Plan:
- Basic frame: hunger=3, happiness=4, health=5, hygiene=6, energy=7, social=8, status=8'h12, tx_ready=1, pulse req -> tx_valid high one cycle later. Bytes A5, 34, 56, 78, 12, AD on consecutive cycles; frame_count=1; busy drops after AD.
- Backpressure: same stats, tx_ready toggling 1,0,0,1,... -> each byte held stable until accepted, no byte skipped or repeated, checksum still AD.
- Snapshot integrity: change hunger to F after B0 is accepted -> B1 still 34; next frame carries F4.
- Pending and collapse: three req pulses during frame 1 -> exactly one extra frame, started the cycle after frame 1's B5 with no bubble; frame_count=2 at the end.
- Periodic: TICKS_PER_REPORT=3, ten `second` pulses, req=0 -> frames start after pulses 3, 6 and 9; frame_count=3. req on the same cycle as pulse 3 -> still a single frame.
- Reset mid-frame: assert reset during B2 -> next cycle tx_valid=0, busy=0, frame_count=0. After release, a req yields a full frame starting with A5.

Source files
------------

// File: rtl/report_pkg.sv
// Shared constants and state encoding for the stat report sequencer.
// The frame is header, three packed stat pairs, status, then an XOR checksum.
package report_pkg;
    localparam int         FRAME_LEN      = 6;
    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    localparam logic [2:0] IDX_HDR     = 3'd0;
    localparam logic [2:0] IDX_HUN_HAP = 3'd1;
    localparam logic [2:0] IDX_HEA_HYG = 3'd2;
    localparam logic [2:0] IDX_ENE_SOC = 3'd3;
    localparam logic [2:0] IDX_STATUS  = 3'd4;
    localparam logic [2:0] IDX_CSUM    = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;
endpackage

// File: rtl/report_tick_div.sv
// Divides the once-per-second pulse down to one auto-report trigger every
// TICKS_PER_REPORT pulses; the trigger is asserted in the cycle of the final pulse.
module report_tick_div #(
    parameter int TICKS_PER_REPORT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic second,
    output logic auto_trig
);
    localparam logic [7:0] LAST_TICK = 8'(TICKS_PER_REPORT - 1);

    logic [7:0] r_cnt;
    logic       w_wrap;

    assign w_wrap    = second && (r_cnt == LAST_TICK);
    assign auto_trig = w_wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (second) begin
            r_cnt <= w_wrap ? 8'd0 : r_cnt + 8'd1;
        end
    end
endmodule

// File: rtl/stat_report_sequencer.sv
// Snapshots the pet stats on a periodic or manual trigger and streams a 6-byte
// frame to the UART; one trigger arriving mid-frame is queued, more are dropped.
module stat_report_sequencer
    import report_pkg::*;
#(
    parameter int         TICKS_PER_REPORT = 1,
    parameter logic [7:0] HEADER           = DEFAULT_HEADER
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       second,
    input  logic       req,
    input  logic [3:0] hunger,
    input  logic [3:0] happiness,
    input  logic [3:0] health,
    input  logic [3:0] hygiene,
    input  logic [3:0] energy,
    input  logic [3:0] social,
    input  logic [7:0] status,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy,
    output logic [7:0] frame_count,
    output state_t     dbg_state
);
    // Handshake: a byte moves on any cycle with tx_valid & tx_ready; while
    // tx_valid is high and tx_ready low, tx_data holds. tx_ready alone does nothing.
    state_t     r_state, w_state;
    logic [2:0] r_idx, w_idx;
    logic [7:0] r_tx_data, w_tx_data;
    logic       r_tx_valid, w_tx_valid;
    logic       r_pending, w_pending;
    logic [7:0] r_csum, w_csum;
    logic [7:0] r_frame_count, w_frame_count;
    logic [7:0] r_b1, r_b2, r_b3, r_b4;
    logic [7:0] w_b1, w_b2, w_b3, w_b4;
    logic       w_auto_trig, w_trig, w_xfer, w_load;
    logic [2:0] w_next_idx;
    logic [7:0] w_next_byte;

    report_tick_div #(
        .TICKS_PER_REPORT(TICKS_PER_REPORT)
    ) u_tick_div (
        .clk      (clk),
        .reset    (reset),
        .second   (second),
        .auto_trig(w_auto_trig)
    );

    assign w_trig     = w_auto_trig | req;
    assign w_xfer     = r_tx_valid & tx_ready;
    assign w_next_idx = r_idx + 3'd1;

    // The checksum byte is the running XOR folded with the byte leaving now.
    always_comb begin
        w_next_byte = HEADER;
        case (w_next_idx)
            IDX_HUN_HAP: w_next_byte = r_b1;
            IDX_HEA_HYG: w_next_byte = r_b2;
            IDX_ENE_SOC: w_next_byte = r_b3;
            IDX_STATUS:  w_next_byte = r_b4;
            IDX_CSUM:    w_next_byte = r_csum ^ r_tx_data;
            default:     w_next_byte = HEADER;
        endcase
    end

    always_comb begin
        w_state       = r_state;
        w_idx         = r_idx;
        w_tx_data     = r_tx_data;
        w_tx_valid    = r_tx_valid;
        w_pending     = r_pending;
        w_csum        = r_csum;
        w_frame_count = r_frame_count;
        w_b1          = r_b1;
        w_b2          = r_b2;
        w_b3          = r_b3;
        w_b4          = r_b4;
        w_load        = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_trig) begin
                    w_load  = 1'b1;
                    w_state = SEND;
                end
            end
            SEND: begin
                if (w_xfer && (r_idx == IDX_CSUM)) begin
                    w_frame_count = r_frame_count + 8'd1;
                    if (r_pending || w_trig) begin
                        w_load    = 1'b1;
                        w_pending = 1'b0;
                    end else begin
                        w_state    = IDLE;
                        w_tx_valid = 1'b0;
                        w_tx_data  = 8'd0;
                    end
                end else begin
                    if (w_xfer) begin
                        w_idx     = w_next_idx;
                        w_tx_data = w_next_byte;
                        w_csum    = r_csum ^ r_tx_data;
                    end
                    if (w_trig) begin
                        w_pending = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (w_load) begin
            w_b1       = {hunger, happiness};
            w_b2       = {health, hygiene};
            w_b3       = {energy, social};
            w_b4       = status;
            w_idx      = IDX_HDR;
            w_tx_data  = HEADER;
            w_tx_valid = 1'b1;
            w_csum     = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_idx         <= IDX_HDR;
            r_tx_data     <= 8'd0;
            r_tx_valid    <= 1'b0;
            r_pending     <= 1'b0;
            r_csum        <= 8'd0;
            r_frame_count <= 8'd0;
            r_b1          <= 8'd0;
            r_b2          <= 8'd0;
            r_b3          <= 8'd0;
            r_b4          <= 8'd0;
        end else begin
            r_state       <= w_state;
            r_idx         <= w_idx;
            r_tx_data     <= w_tx_data;
            r_tx_valid    <= w_tx_valid;
            r_pending     <= w_pending;
            r_csum        <= w_csum;
            r_frame_count <= w_frame_count;
            r_b1          <= w_b1;
            r_b2          <= w_b2;
            r_b3          <= w_b3;
            r_b4          <= w_b4;
        end
    end

    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign busy        = (r_state == SEND);
    assign frame_count = r_frame_count;
    assign dbg_state   = r_state;
endmodule

// File: tb/tb_stat_report_sequencer.sv
// Bench for stat_report_sequencer: fixed frame vectors, hand-built corner
// sequences and a random run, all cross-checked against a frame-level model.
module tb_stat_report_sequencer;
  import report_pkg::*;

  localparam int T = 3;

  logic       clk = 1'b0;
  logic       reset, second, req, tx_ready;
  logic [3:0] hunger, happiness, health, hygiene, energy, social;
  logic [7:0] status;
  logic [7:0] tx_data, frame_count;
  logic       tx_valid, busy;
  state_t     dbg_state;

  always #5 clk = ~clk;

  stat_report_sequencer #(
    .TICKS_PER_REPORT(T),
    .HEADER(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .second(second), .req(req),
    .hunger(hunger), .happiness(happiness), .health(health),
    .hygiene(hygiene), .energy(energy), .social(social),
    .status(status), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .busy(busy), .frame_count(frame_count),
    .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of bytes queued at snapshot time;
  // the link is either idle or working through the queue, with one spare slot.
  logic [7:0] exp_q[$];
  int         m_ticks = 0;
  int         m_left = 0;
  bit         m_busy = 0;
  bit         m_pending = 0;
  logic [7:0] m_count = 8'd0;
  bit         chk_en = 0;

  function automatic void push_frame();
    logic [7:0] b [6];
    b[0] = 8'hA5;
    b[1] = {hunger, happiness};
    b[2] = {health, hygiene};
    b[3] = {energy, social};
    b[4] = status;
    b[5] = 8'h00;
    for (int i = 0; i < 5; i++) b[5] = b[5] ^ b[i];
    for (int i = 0; i < 6; i++) exp_q.push_back(b[i]);
  endfunction

  always @(posedge clk) begin : ref_model
    bit trig;
    if (reset) begin
      m_ticks = 0; m_left = 0; m_busy = 0; m_pending = 0; m_count = 8'd0;
      exp_q.delete();
      chk_en = 1;
    end else begin
      trig = req;
      if (second) begin
        m_ticks++;
        if (m_ticks == T) begin
          m_ticks = 0;
          trig = 1;
        end
      end
      if (m_busy && tx_ready) begin
        void'(exp_q.pop_front());
        m_left--;
        if (m_left == 0) begin
          m_count = m_count + 8'd1;
          if (m_pending || trig) begin
            push_frame();
            m_left = 6;
            m_pending = 0;
            trig = 0;
          end else begin
            m_busy = 0;
          end
        end
      end
      if (trig) begin
        if (!m_busy) begin
          push_frame();
          m_busy = 1;
          m_left = 6;
        end else begin
          m_pending = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", busy, m_busy);
      chk("model_tx_valid", tx_valid, m_busy);
      chk("model_frame_count", frame_count, m_count);
      if (m_busy) chk("model_tx_data", tx_data, exp_q.size() > 0 ? exp_q[0] : 8'hxx);
    end
  end

  typedef struct {
    logic [3:0] hun, hap, hea, hyg, ene, soc;
    logic [7:0] st;
    logic [5:0][7:0] exp;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] cap[$];
  int         fc_exp, first_c, last_c, nvalid;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_stats(input logic [3:0] h0, h1, h2, h3, h4, h5, input logic [7:0] st);
    hunger = h0; happiness = h1; health = h2; hygiene = h3; energy = h4; social = h5;
    status = st;
  endtask

  // Drives tx_ready each cycle (mode 0: always, mode 1: 1,0,0,1 pattern) and
  // records accepted bytes until n have been collected or the budget runs out.
  task automatic capture(input int max_cycles, input int n, input int mode);
    for (int c = 0; c < max_cycles && cap.size() < n; c++) begin
      tx_ready = (mode == 0) ? 1'b1 : ((c % 4) == 0 || (c % 4) == 3);
      @(negedge clk);
      if (tx_valid && tx_ready) cap.push_back(tx_data);
      step();
    end
    tx_ready = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    fc_exp = 0;
  endtask

  initial begin
    vecs[0] = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 8'h12, {8'hA5, 8'h34, 8'h56, 8'h78, 8'h12, 8'hAD}};
    vecs[1] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5}};
    vecs[2] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 8'hFF, {8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hA5}};
    vecs[3] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hA, 4'h5, 8'hC3, {8'hA5, 8'h12, 8'h48, 8'hA5, 8'hC3, 8'h99}};

    reset = 1'b1; second = 1'b0; req = 1'b0; tx_ready = 1'b0;
    set_stats(4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 8'h12);
    fc_exp = 0;
    step();
    step();
    @(negedge clk);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_count", frame_count, 8'h00);
    step();
    reset = 1'b0;
    step();

    // Table-driven frames at full rate
    foreach (vecs[v]) begin
      set_stats(vecs[v].hun, vecs[v].hap, vecs[v].hea, vecs[v].hyg, vecs[v].ene, vecs[v].soc, vecs[v].st);
      tx_ready = 1'b1;
      req = 1'b1;
      step();
      req = 1'b0;
      @(negedge clk);
      chk("vec_latency_valid", tx_valid, 1'b1);
      for (int k = 0; k < 6; k++) begin
        chk("vec_byte", tx_data, vecs[v].exp[5 - k]);
        step();
        @(negedge clk);
      end
      fc_exp++;
      chk("vec_busy_drop", busy, 1'b0);
      chk("vec_valid_drop", tx_valid, 1'b0);
      chk("vec_frame_count", frame_count, 8'(fc_exp));
      step();
    end

    // Backpressure with the 1,0,0,1 ready pattern
    set_stats(4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 8'h12);
    req = 1'b1;
    step();
    req = 1'b0;
    cap.delete();
    capture(60, 6, 1);
    chk("bp_count", cap.size(), 6);
    if (cap.size() == 6) begin
      for (int k = 0; k < 6; k++) chk("bp_byte", cap[k], vecs[0].exp[5 - k]);
    end
    repeat (3) step();
    fc_exp++;
    chk("bp_frame_count", frame_count, 8'(fc_exp));

    // Snapshot integrity: stat change after B0 must not leak into the frame
    req = 1'b1;
    step();
    req = 1'b0;
    cap.delete();
    capture(10, 1, 0);
    hunger = 4'hF;
    capture(20, 6, 0);
    chk("snap_count", cap.size(), 6);
    if (cap.size() == 6) begin
      chk("snap_b1", cap[1], 8'h34);
      chk("snap_csum", cap[5], 8'hAD);
    end
    repeat (3) step();
    req = 1'b1;
    step();
    req = 1'b0;
    cap.delete();
    capture(20, 6, 0);
    chk("snap_next_count", cap.size(), 6);
    if (cap.size() == 6) begin
      chk("snap_next_b1", cap[1], 8'hF4);
      chk("snap_next_csum", cap[5], 8'h6D);
    end
    fc_exp += 2;
    hunger = 4'h3;
    repeat (3) step();

    // Three requests during a frame collapse into one back-to-back frame
    req = 1'b1;
    step();
    req = 1'b0;
    cap.delete();
    nvalid = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 30; c++) begin
      tx_ready = 1'b1;
      req = (c == 1 || c == 2 || c == 4);
      @(negedge clk);
      if (tx_valid) begin
        nvalid++;
        if (first_c < 0) first_c = c;
        last_c = c;
        cap.push_back(tx_data);
      end
      step();
    end
    req = 1'b0;
    chk("pend_valid_cycles", nvalid, 12);
    chk("pend_no_bubble", last_c - first_c + 1, 12);
    if (cap.size() == 12) begin
      chk("pend_second_hdr", cap[6], 8'hA5);
      chk("pend_second_csum", cap[11], 8'hAD);
    end
    fc_exp += 2;
    chk("pend_frame_count", frame_count, 8'(fc_exp));

    // Periodic reports every T second pulses
    do_reset();
    for (int p = 1; p <= 10; p++) begin
      second = 1'b1;
      step();
      second = 1'b0;
      @(negedge clk);
      chk("periodic_start", tx_valid, (p % 3) == 0);
      repeat (10) step();
    end
    chk("periodic_frame_count", frame_count, 8'd3);

    // Manual request coinciding with the auto trigger yields one frame
    do_reset();
    for (int p = 1; p <= 3; p++) begin
      second = 1'b1;
      req = (p == 3);
      step();
      second = 1'b0;
      req = 1'b0;
      nvalid = 0;
      for (int c = 0; c < 15; c++) begin
        @(negedge clk);
        if (tx_valid) nvalid++;
        step();
      end
    end
    chk("coincide_valid_cycles", nvalid, 6);
    chk("coincide_frame_count", frame_count, 8'd1);

    // Reset while B2 is on the bus abandons the frame
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("midrst_b2_present", tx_data, 8'h56);
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("midrst_tx_valid", tx_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_frame_count", frame_count, 8'h00);
    step();
    reset = 1'b0;
    step();
    req = 1'b1;
    step();
    req = 1'b0;
    cap.delete();
    capture(20, 6, 0);
    chk("midrst_count", cap.size(), 6);
    if (cap.size() == 6) begin
      chk("midrst_hdr", cap[0], 8'hA5);
      chk("midrst_csum", cap[5], 8'hAD);
    end
    repeat (3) step();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ((c % 8) == 0) begin
        set_stats(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  8'($urandom_range(0, 255)));
      end
      req = ($urandom_range(0, 19) == 0);
      second = ($urandom_range(0, 9) == 0);
      tx_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req = 1'b0;
    second = 1'b0;
    tx_ready = 1'b1;
    repeat (30) step();
    @(negedge clk);
    chk("drain_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
